// File: rtl/i2c_master_multibyte.sv
// ---------------------------------------------------------------------------
// i2c_master_multibyte
//   I2C master for the wb_i2c subsystem. Performs one transfer per start
//   request: START, 7-bit address + R/W, then 0..MAX_BYTES payload bytes
//   (write or read), then STOP. Every slave ACK slot is checked and a NACK
//   aborts the transfer straight into STOP.
//
//   Optional feature macro: I2C_CLOCK_STRETCH_EN
//     defined   : i2c_sclk is open-drain inout; the divider holds in the
//                 SCL-high sampling quarter while a slave keeps SCL low.
//     undefined : i2c_sclk is a push-pull output and is never sampled.
//
// Ports
//   clk_n     system clock, all logic on its rising edge
//   reset     synchronous, active-high
//   start     transfer request, only looked at while idle
//   dev_addr  7-bit slave address
//   rw        0 = write, 1 = read
//   len       payload byte count (clamped to MAX_BYTES), 0 = address probe
//   wdata     write payload, byte k = wdata[8k+7:8k], byte 0 first, MSB first
//   rdata     read payload, same byte mapping
//   busy      high from accept until the done cycle
//   done      one-cycle pulse at the end of every transfer
//   ack_ok    with done: 1 = every slave ACK was seen
//   nack_idx  with done and !ack_ok: 0 = address NACK, k+1 = write byte k
//   i2c_sclk  SCL, high while idle
//   i2c_sdat  SDA, open-drain (drive 0 or release)
// ---------------------------------------------------------------------------
module i2c_master_multibyte #(
   parameter int CLK_DIV   = 128,
   parameter int MAX_BYTES = 4,
   localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
   input  logic                   clk_n,
   input  logic                   reset,
   input  logic                   start,
   input  logic [6:0]             dev_addr,
   input  logic                   rw,
   input  logic [LEN_W-1:0]       len,
   input  logic [8*MAX_BYTES-1:0] wdata,
   output logic [8*MAX_BYTES-1:0] rdata,
   output logic                   busy,
   output logic                   done,
   output logic                   ack_ok,
   output logic [LEN_W-1:0]       nack_idx,
`ifdef I2C_CLOCK_STRETCH_EN
   inout  wire                    i2c_sclk,
`else
   output logic                   i2c_sclk,
`endif
   inout  wire                    i2c_sdat
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] Q0_END   = DIV_W'(CLK_DIV/4 - 1);
   localparam logic [DIV_W-1:0] Q1_END   = DIV_W'(CLK_DIV/2 - 1);
   localparam logic [DIV_W-1:0] Q2_START = DIV_W'(CLK_DIV/2);
   localparam logic [DIV_W-1:0] Q2_END   = DIV_W'(3*CLK_DIV/4 - 1);
   localparam logic [DIV_W-1:0] BIT_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] SDA_REL  = DIV_W'(CLK_DIV - 2);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, AACK, WR_BYTE, WACK, RD_BYTE, RACK, STOP
   } state_t;

   state_t state, state_next;

   logic [DIV_W-1:0]       div;
   logic [2:0]             bit_cnt;
   logic [LEN_W-1:0]       byte_idx;
   logic [6:0]             addr_q;
   logic                   rw_q;
   logic [LEN_W-1:0]       len_q;
   logic [8*MAX_BYTES-1:0] wdata_q;
   logic [8*MAX_BYTES-1:0] rdata_q;
   logic [7:0]             rx_shift;
   logic                   sample_q;
   logic                   nack_q;
   logic [LEN_W-1:0]       nack_idx_q;
   logic                   ack_ok_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   scl_q;
   logic                   sda_low_q;
   logic                   stretch_hold;
   logic                   tick;
   logic                   bit_end;
   logic                   is_last;
   logic [7:0]             addr_byte;

   assign addr_byte = {addr_q, rw_q};
   assign is_last   = (byte_idx == (len_q - LEN_W'(1)));
   assign tick      = (state != IDLE) && !stretch_hold;
   assign bit_end   = tick && (div == BIT_LAST);

   // SCL is sampled directly (no synchronizer) so an unstretched bit keeps
   // its exact length; a stretching slave just extends the high quarter.
`ifdef I2C_CLOCK_STRETCH_EN
   assign stretch_hold = (state != IDLE) && scl_q && !i2c_sclk &&
                         (div >= Q2_START) && (div <= Q2_END);
   assign i2c_sclk     = scl_q ? 1'bz : 1'b0;
`else
   assign stretch_hold = 1'b0;
   assign i2c_sclk     = scl_q;
`endif

   assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

   assign rdata    = rdata_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ack_ok   = ack_ok_q;
   assign nack_idx = nack_idx_q;

   // State register; reset aborts any transfer at the same edge.
   always_ff @(posedge clk_n) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state: every transition happens at the last cycle of a bit, and
   // ACK decisions use the SDA value captured at the end of quarter 2.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = START;
         START:   if (bit_end) state_next = ADDR;
         ADDR:    if (bit_end && bit_cnt == 3'd0) state_next = AACK;
         AACK:    if (bit_end) begin
                     if (sample_q || len_q == '0) state_next = STOP;
                     else if (rw_q)               state_next = RD_BYTE;
                     else                         state_next = WR_BYTE;
                  end
         WR_BYTE: if (bit_end && bit_cnt == 3'd0) state_next = WACK;
         WACK:    if (bit_end) state_next = (sample_q || is_last) ? STOP : WR_BYTE;
         RD_BYTE: if (bit_end && bit_cnt == 3'd0) state_next = RACK;
         RACK:    if (bit_end) state_next = is_last ? STOP : RD_BYTE;
         STOP:    if (bit_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and bus pins. Within a bit: SDA updates at end of Q0, SCL
   // rises at end of Q1, SDA is sampled at end of Q2, SCL falls at bit end.
   // START instead drops SDA at end of Q1 with SCL already high; STOP
   // releases SDA one cycle before its bit ends so done follows it.
   always_ff @(posedge clk_n) begin
      if (reset) begin
         div        <= '0;
         bit_cnt    <= 3'd7;
         byte_idx   <= '0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         len_q      <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rx_shift   <= '0;
         sample_q   <= 1'b1;
         nack_q     <= 1'b0;
         nack_idx_q <= '0;
         ack_ok_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         scl_q      <= 1'b1;
         sda_low_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               addr_q     <= dev_addr;
               rw_q       <= rw;
               len_q      <= (len > LEN_MAX) ? LEN_MAX : len;
               wdata_q    <= wdata;
               rdata_q    <= '0;
               div        <= '0;
               bit_cnt    <= 3'd7;
               byte_idx   <= '0;
               nack_q     <= 1'b0;
               nack_idx_q <= '0;
               ack_ok_q   <= 1'b0;
               busy_q     <= 1'b1;
            end
         end else if (tick) begin
            div <= bit_end ? '0 : div + 1'b1;

            if (div == Q0_END) begin
               case (state)
                  ADDR:    sda_low_q <= ~addr_byte[bit_cnt];
                  WR_BYTE: sda_low_q <= ~wdata_q[bit_cnt];
                  RACK:    sda_low_q <= ~is_last;
                  STOP:    sda_low_q <= 1'b1;
                  default: sda_low_q <= 1'b0;
               endcase
            end

            if (div == Q1_END) begin
               if (state == START) sda_low_q <= 1'b1;
               else                scl_q     <= 1'b1;
            end

            if (div == Q2_END) begin
               sample_q <= i2c_sdat;
               if (state == RD_BYTE) rx_shift <= {rx_shift[6:0], i2c_sdat};
            end

            if (state == STOP && div == SDA_REL) sda_low_q <= 1'b0;

            if (bit_end) begin
               if (state != STOP) scl_q <= 1'b0;
               case (state)
                  ADDR, WR_BYTE: bit_cnt <= bit_cnt - 1'b1;
                  RD_BYTE: begin
                     bit_cnt <= bit_cnt - 1'b1;
                     if (bit_cnt == 3'd0) begin
                        for (int k = 0; k < MAX_BYTES; k++) begin
                           if (byte_idx == LEN_W'(k)) rdata_q[8*k +: 8] <= rx_shift;
                        end
                     end
                  end
                  AACK: begin
                     if (sample_q) begin
                        nack_q     <= 1'b1;
                        nack_idx_q <= '0;
                     end
                  end
                  WACK: begin
                     if (sample_q) begin
                        nack_q     <= 1'b1;
                        nack_idx_q <= byte_idx + 1'b1;
                     end else if (!is_last) begin
                        byte_idx <= byte_idx + 1'b1;
                        wdata_q  <= wdata_q >> 8;
                     end
                  end
                  RACK: if (!is_last) byte_idx <= byte_idx + 1'b1;
                  STOP: begin
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     ack_ok_q <= ~nack_q;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_multibyte.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_multibyte
//   Directed bench for i2c_master_multibyte (CLK_DIV=8, MAX_BYTES=4) with a
//   behavioural I2C slave that decodes the bus, ACKs its own address and
//   write bytes (optionally NACKing one), and serves read bytes.
// ---------------------------------------------------------------------------
module tb_i2c_master_multibyte;

   localparam int CLK_DIV   = 8;
   localparam int MAX_BYTES = 4;

   logic        clk_n = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  dev_addr = '0;
   logic        rw = 1'b0;
   logic [2:0]  len = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        ack_ok;
   logic [2:0]  nack_idx;
   wire         scl_bus;
   wire         sda_bus;

   int passes = 0;
   int checks = 0;

   // slave model state
   logic [6:0]  slave_addr = 7'h1A;
   int          nack_at = -1;
   logic [7:0]  rd_bytes [4];
   logic        slave_low = 1'b0;
   logic        scl_prev = 1'b1;
   logic        sda_prev = 1'b1;
   logic        in_xfer = 1'b0;
   logic        skip_fall = 1'b0;
   logic        reading = 1'b0;
   logic        mack = 1'b0;
   logic [7:0]  rx_byte = '0;
   int          slot = 0;
   int          bn = 0;
   int          stop_cnt = 0;
   logic [7:0]  got_bytes [$];
   logic        mack_log [$];

   pullup (sda_bus);
`ifdef I2C_CLOCK_STRETCH_EN
   pullup (scl_bus);
`endif
   assign sda_bus = slave_low ? 1'b0 : 1'bz;

   i2c_master_multibyte #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
      .clk_n(clk_n), .reset(reset), .start(start), .dev_addr(dev_addr),
      .rw(rw), .len(len), .wdata(wdata), .rdata(rdata), .busy(busy),
      .done(done), .ack_ok(ack_ok), .nack_idx(nack_idx),
      .i2c_sclk(scl_bus), .i2c_sdat(sda_bus)
   );

   always #5 clk_n = ~clk_n;

   // Slave: bit slots 0..7 are data, slot 8 is the ACK slot; START/STOP are
   // SDA edges while SCL is high.
   always @(scl_bus or sda_bus) begin
      if (scl_bus !== scl_prev) begin
         if (scl_bus === 1'b1) begin
            if (in_xfer) begin
               if (slot < 8) rx_byte = {rx_byte[6:0], sda_bus};
               else begin
                  mack = (sda_bus === 1'b0);
                  if (reading && bn > 0) mack_log.push_back(mack);
               end
            end
         end else if (in_xfer) begin
            if (skip_fall) skip_fall = 1'b0;
            else if (slot < 7) begin
               slot++;
               if (reading && mack && bn > 0 && bn <= 4) slave_low = ~rd_bytes[bn-1][7-slot];
            end else if (slot == 7) begin
               slot = 8;
               if (bn == 0) begin
                  reading = rx_byte[0];
                  slave_low = (rx_byte[7:1] == slave_addr);
                  got_bytes.push_back(rx_byte);
               end else if (!reading) begin
                  got_bytes.push_back(rx_byte);
                  slave_low = ((bn - 1) != nack_at);
               end else slave_low = 1'b0;
            end else begin
               slot = 0;
               bn++;
               slave_low = 1'b0;
               if (reading && mack && bn <= 4) slave_low = ~rd_bytes[bn-1][7];
            end
         end
      end else if (scl_bus === 1'b1 && sda_prev !== sda_bus) begin
         if (sda_bus === 1'b0) begin
            in_xfer = 1'b1; skip_fall = 1'b1; slot = 0; bn = 0;
            mack = 1'b0; reading = 1'b0;
            got_bytes.delete();
            mack_log.delete();
         end else begin
            in_xfer = 1'b0;
            slave_low = 1'b0;
            stop_cnt++;
         end
      end
      scl_prev = scl_bus;
      sda_prev = sda_bus;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // One transfer: accept edge, then count edges until done (bounded).
   task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [2:0] l,
                                input logic [31:0] wd, output int cyc,
                                output logic busy_after, output logic busy_at_done);
      @(negedge clk_n);
      dev_addr = a; rw = r; len = l; wdata = wd; start = 1'b1;
      @(posedge clk_n); #1;
      start = 1'b0;
      busy_after = busy;
      cyc = 0;
      do begin
         @(posedge clk_n); #1;
         cyc++;
      end while (!done && cyc < 2000);
      busy_at_done = busy;
      if (!done) cyc = -1;
   endtask

   function automatic logic [63:0] packBytes();
      logic [63:0] p = '0;
      foreach (got_bytes[i]) p = {p[55:0], got_bytes[i]};
      return p;
   endfunction

   initial begin
      int cyc;
      int stops0;
      logic b_after, b_done, done_seen, busy_seen;
      logic [63:0] mpack;

      rd_bytes[0] = 8'hA5; rd_bytes[1] = 8'h3C; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;

      // reset state
      repeat (3) @(posedge clk_n);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_ack_ok", ack_ok, 0);
      checkOutput("rst_nack_idx", nack_idx, 0);
      checkOutput("rst_rdata", rdata, 0);
      checkOutput("rst_scl", scl_bus, 1);
      checkOutput("rst_sda", sda_bus, 1);
      @(negedge clk_n);
      reset = 1'b0;

      // full write, all ACK
      stops0 = stop_cnt;
      applyStimulus(7'h1A, 1'b0, 3'd3, 32'h005533CC, cyc, b_after, b_done);
      checkOutput("wr_busy_after_accept", b_after, 1);
      checkOutput("wr_done_cycle", cyc, 304);
      checkOutput("wr_busy_in_done", b_done, 0);
      checkOutput("wr_ack_ok", ack_ok, 1);
      checkOutput("wr_byte_count", got_bytes.size(), 4);
      checkOutput("wr_bytes", packBytes(), 64'h34CC3355);
      checkOutput("wr_stop_seen", stop_cnt - stops0, 1);

      // slave NACKs write byte 1
      nack_at = 1;
      applyStimulus(7'h1A, 1'b0, 3'd3, 32'h005533CC, cyc, b_after, b_done);
      nack_at = -1;
      checkOutput("nack_done_cycle", cyc, 232);
      checkOutput("nack_ack_ok", ack_ok, 0);
      checkOutput("nack_idx", nack_idx, 2);
      checkOutput("nack_byte_count", got_bytes.size(), 3);
      checkOutput("nack_bytes", packBytes(), 64'h34CC33);

      // two-byte read
      slave_addr = 7'h50;
      applyStimulus(7'h50, 1'b1, 3'd2, 32'h0, cyc, b_after, b_done);
      checkOutput("rd_done_cycle", cyc, 232);
      checkOutput("rd_ack_ok", ack_ok, 1);
      checkOutput("rd_rdata", rdata, 32'h00003CA5);
      mpack = '0;
      foreach (mack_log[i]) mpack = {mpack[62:0], mack_log[i]};
      checkOutput("rd_master_ack_count", mack_log.size(), 2);
      checkOutput("rd_master_acks", mpack, 2'b10);

      // probe of an absent address
      slave_addr = 7'h1A;
      applyStimulus(7'h23, 1'b1, 3'd0, 32'h0, cyc, b_after, b_done);
      checkOutput("probe_done_cycle", cyc, 88);
      checkOutput("probe_ack_ok", ack_ok, 0);
      checkOutput("probe_nack_idx", nack_idx, 0);
      checkOutput("probe_rdata_cleared", rdata, 0);

      // len above MAX_BYTES is clamped
      applyStimulus(7'h1A, 1'b0, 3'd7, 32'h11223344, cyc, b_after, b_done);
      checkOutput("clamp_done_cycle", cyc, 376);
      checkOutput("clamp_byte_count", got_bytes.size(), 5);
      checkOutput("clamp_bytes", packBytes(), 64'h3444332211);
      checkOutput("clamp_ack_ok", ack_ok, 1);

      // start while busy is ignored, reset mid-byte aborts silently
      stops0 = stop_cnt;
      @(negedge clk_n);
      dev_addr = 7'h1A; rw = 1'b0; len = 3'd1; wdata = 32'hF0; start = 1'b1;
      @(posedge clk_n); #1;
      start = 1'b0;
      repeat (12) @(posedge clk_n);
      @(negedge clk_n);
      dev_addr = 7'h7F; len = 3'd2; start = 1'b1;
      @(posedge clk_n); #1;
      start = 1'b0;
      checkOutput("busy_start_busy", busy, 1);
      repeat (16) @(posedge clk_n);
      @(negedge clk_n);
      reset = 1'b1;
      @(posedge clk_n); #1;
      checkOutput("midrst_scl", scl_bus, 1);
      checkOutput("midrst_sda", sda_bus, 1);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      @(negedge clk_n);
      reset = 1'b0;
      done_seen = 1'b0;
      busy_seen = 1'b0;
      repeat (400) begin
         @(posedge clk_n); #1;
         if (done) done_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
      checkOutput("after_rst_no_done", done_seen, 0);
      checkOutput("after_rst_no_busy", busy_seen, 0);
      checkOutput("after_rst_no_stop", stop_cnt - stops0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
